fpu_bus_master: RTL and testbench

Bus initiator that drives the memory-mapped FPU peripheral over its 8-bit register bus. It accepts a 32-bit operand pair and an opcode on a valid/ready request port, then writes the operand bytes and opcode to the FPU. It waits for completion, reads back the four result bytes and returns the assembled IEEE-754 single on a valid/ready response port. It sits between a CPU-side command source and the FPU `cs`/`rd`/`wr` slave interface.

---
 rtl/fpu_bus_master.sv | 226 ++++++++++++++++++++++
 tb/tb_fpu_bus_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_bus_master.sv
// fpu_bus_master
//   Bus initiator for the memory-mapped FPU peripheral. A request carries two
//   32-bit operands and an opcode. The block writes the operand bytes and then
//   the opcode over the 8-bit cs/rd/wr register bus. It waits for completion,
//   reads back the four result bytes, and returns the assembled single-precision
//   result on a response port.
//
//   Optional feature macro: FPU_MASTER_IRQ_WAIT_EN
//     defined   : WAIT holds until cmd_end, then end_ack pulses for one clock
//                 (ACK). If cmd_end does not arrive in TIMEOUT_CYCLES, the
//                 response is returned with rsp_timeout=1 and a zero result.
//     undefined : WAIT lasts exactly SETTLE_CYCLES. cmd_end is ignored, and
//                 end_ack and rsp_timeout are tied 0.
//
//   Ports
//     clk, arst              clock; asynchronous active-low reset
//     req_valid/req_ready    request handshake (req_op, req_a, req_b)
//     rsp_valid/rsp_ready    response handshake (rsp_result, rsp_timeout)
//     addr, databus_out      FPU register address / write data
//     databus_in             FPU read data
//     cs, rd, wr             active-low chip select / read / write strobes
//     cmd_end, busy          FPU end-of-command / operation in progress
//     end_ack                end-of-command acknowledge
//     dbg_state              current FSM state (state_t encoding)
//
//   Handshake semantics (both ports): a transfer happens on a rising clk edge
//   where valid && ready are both high. Once raised, rsp_valid stays high and
//   the payload stays stable until that transfer. req_ready is combinational
//   and is high only in IDLE while busy is low.
module fpu_bus_master #(
  parameter int STROBE_CYCLES  = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [5:0]  addr,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [7:0]  databus_out,
  input  logic [7:0]  databus_in,
  input  logic        cmd_end,
  input  logic        busy,
  output logic        end_ack,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WAIT = 3'd2,
    S_ACK  = 3'd3,
    S_RD   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // Sub-phases of one bus access: SETUP (1 clk), STROBE (STROBE_CYCLES), HOLD (1 clk)
  typedef enum logic [1:0] {
    P_SETUP  = 2'd0,
    P_STROBE = 2'd1,
    P_HOLD   = 2'd2
  } phase_t;

  state_t      state, state_d;
  phase_t      phase;
  logic [3:0]  scnt;      // strobe clock counter
  logic [3:0]  bcnt;      // byte index within the current phase group
  logic [15:0] wcnt;      // clocks spent in WAIT
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic [31:0] result_q;
  logic [7:0]  wr_byte;
  logic        strobe_last;
  logic        last_access;
  logic        accept;

  assign accept      = req_valid && req_ready;
  assign strobe_last = (scnt == 4'(STROBE_CYCLES - 1));
  // The final HOLD of a group ends the group: byte 8 for writes, byte 3 for reads
  assign last_access = (phase == P_HOLD) &&
                       (bcnt == ((state == S_WR) ? 4'd8 : 4'd3));

  assign req_ready  = (state == S_IDLE) && !busy;
  assign rsp_valid  = (state == S_RESP);
  assign rsp_result = result_q;
  assign dbg_state  = state;

  // Write byte order: a LSB first, then b LSB first, then the opcode last
  always_comb begin
    wr_byte = 8'h00;
    case (bcnt)
      4'd0: wr_byte = a_q[7:0];
      4'd1: wr_byte = a_q[15:8];
      4'd2: wr_byte = a_q[23:16];
      4'd3: wr_byte = a_q[31:24];
      4'd4: wr_byte = b_q[7:0];
      4'd5: wr_byte = b_q[15:8];
      4'd6: wr_byte = b_q[23:16];
      4'd7: wr_byte = b_q[31:24];
      4'd8: wr_byte = {4'h0, op_q};
      default: wr_byte = 8'h00;
    endcase
  end

  // Bus outputs are decoded from registered state, so an asynchronous reset
  // returns them to idle levels immediately.
  always_comb begin
    cs          = 1'b1;
    rd          = 1'b1;
    wr          = 1'b1;
    addr        = 6'd0;
    databus_out = 8'h00;
    if (state == S_WR) begin
      cs          = 1'b0;
      addr        = {2'b00, bcnt};
      databus_out = wr_byte;
      wr          = (phase != P_STROBE);
    end else if (state == S_RD) begin
      cs   = 1'b0;
      addr = 6'd9 + {2'b00, bcnt};
      rd   = (phase != P_STROBE);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = S_WR;
      S_WR:   if (last_access) state_d = S_WAIT;
`ifdef FPU_MASTER_IRQ_WAIT_EN
      S_WAIT: begin
        if (cmd_end)                                  state_d = S_ACK;
        else if (wcnt == 16'(TIMEOUT_CYCLES - 1))     state_d = S_RESP;
      end
      S_ACK:  state_d = S_RD;
`else
      S_WAIT: if (wcnt == 16'(SETTLE_CYCLES - 1))     state_d = S_RD;
`endif
      S_RD:   if (last_access) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      phase    <= P_SETUP;
      scnt     <= 4'd0;
      bcnt     <= 4'd0;
      wcnt     <= 16'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 4'd0;
      result_q <= 32'd0;
    end else begin
      if (state == S_IDLE && accept) begin
        a_q      <= req_a;
        b_q      <= req_b;
        op_q     <= req_op;
        result_q <= 32'd0;
        phase    <= P_SETUP;
        scnt     <= 4'd0;
        bcnt     <= 4'd0;
      end
      if (state == S_WR || state == S_RD) begin
        case (phase)
          P_SETUP: phase <= P_STROBE;
          P_STROBE: begin
            if (strobe_last) begin
              phase <= P_HOLD;
              scnt  <= 4'd0;
              // Read data is taken on the edge that ends the last strobe clock
              if (state == S_RD) result_q[{bcnt[1:0], 3'b000} +: 8] <= databus_in;
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          P_HOLD: begin
            phase <= P_SETUP;
            bcnt  <= last_access ? 4'd0 : bcnt + 4'd1;
          end
          default: phase <= P_SETUP;
        endcase
      end
      if (state == S_WAIT && state_d == S_WAIT) wcnt <= wcnt + 16'd1;
      else                                      wcnt <= 16'd0;
    end
  end

`ifdef FPU_MASTER_IRQ_WAIT_EN
  logic timeout_q;
  logic unused_cfg;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                                     timeout_q <= 1'b0;
    else if (state == S_IDLE && accept)            timeout_q <= 1'b0;
    else if (state == S_WAIT && state_d == S_RESP) timeout_q <= 1'b1;
  end

  assign rsp_timeout = timeout_q;
  assign end_ack     = (state == S_ACK);
  assign unused_cfg  = (SETTLE_CYCLES == 0);
`else
  logic unused_cfg;

  assign rsp_timeout = 1'b0;
  assign end_ack     = 1'b0;
  assign unused_cfg  = cmd_end ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fpu_bus_master.sv
// tb_fpu_bus_master
//   Directed bench for fpu_bus_master with a small FPU bus model. It covers
//   byte order, strobe timing, latency, backpressure, busy blocking and reset
//   in the middle of an operation. It also covers completion, acknowledge and
//   timeout when FPU_MASTER_IRQ_WAIT_EN is defined.
module tb_fpu_bus_master;

  localparam int S      = 2;
  localparam int SETTLE = 4;
  localparam int TMO    = 20;
`ifdef FPU_MASTER_IRQ_WAIT_EN
  localparam int WAIT_CYC = 8;   // 7 clocks until cmd_end plus one ACK clock
  localparam int EXP_ACK  = 1;
`else
  localparam int WAIT_CYC = SETTLE;
  localparam int EXP_ACK  = 0;
`endif
  localparam int LAT = 9 * (2 + S) + WAIT_CYC + 4 * (2 + S) + 1;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic [5:0]  addr;
  logic        cs, rd, wr;
  logic [7:0]  databus_out, databus_in;
  logic        cmd_end = 1'b0;
  logic        busy = 1'b0;
  logic        end_ack;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  // Bus model state
  logic [31:0] model_res = 32'd0;
  logic [5:0]  wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [5:0]  rd_addr_q[$];
  logic [7:0]  exp_q[$];
  int          cs_err = 0, width_err = 0, ack_cyc = 0;
  logic        wr_prev = 1'b1, rd_prev = 1'b1;
  int          wr_w = 0, rd_w = 0;
  bit          irq_on = 1'b1;
  int          irq_cnt = 0;

  fpu_bus_master #(
    .STROBE_CYCLES(S), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr),
    .databus_out(databus_out), .databus_in(databus_in),
    .cmd_end(cmd_end), .busy(busy), .end_ack(end_ack), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // FPU result registers 9..C
  always_comb begin
    databus_in = 8'h00;
    case (addr)
      6'd9:  databus_in = model_res[7:0];
      6'd10: databus_in = model_res[15:8];
      6'd11: databus_in = model_res[23:16];
      6'd12: databus_in = model_res[31:24];
      default: databus_in = 8'h00;
    endcase
  end

  // Bus monitor: records each access at its first strobe clock and checks strobe width
  always @(negedge clk) begin
    if (!arst) begin
      wr_prev = 1'b1; rd_prev = 1'b1; wr_w = 0; rd_w = 0;
    end else begin
      if (cs && (!rd || !wr)) cs_err++;
      if (!wr) begin
        if (wr_prev) begin
          wr_addr_q.push_back(addr); wr_data_q.push_back(databus_out); wr_w = 0;
        end
        wr_w++;
      end else if (!wr_prev && wr_w != S) width_err++;
      if (!rd) begin
        if (rd_prev) begin rd_addr_q.push_back(addr); rd_w = 0; end
        rd_w++;
      end else if (!rd_prev && rd_w != S) width_err++;
      if (end_ack) ack_cyc++;
      wr_prev = wr; rd_prev = rd;
    end
  end

  // FPU completion model: raise cmd_end on the 7th idle clock after the opcode write
  always @(negedge clk) begin
    if (!arst) begin
      cmd_end = 1'b0; irq_cnt = 0;
    end else if (end_ack) begin
      cmd_end = 1'b0; irq_cnt = 0;
    end else if (irq_on && cs && wr_addr_q.size() == 9 && rd_addr_q.size() == 0 && !rsp_valid) begin
      irq_cnt++;
      if (irq_cnt == 7) cmd_end = 1'b1;
    end else begin
      irq_cnt = 0;
    end
  end

  // Driver tasks
  task automatic clear_model(input logic [31:0] res);
    model_res = res;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    ack_cyc = 0;
  endtask

  // Issues one request and returns once rsp_valid is seen (or the bound expires).
  // cyc is the clock number, counted from the accept edge, in which rsp_valid is high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] res, output int cyc);
    int guard;
    clear_model(res);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[8*i +: 8]);
    exp_q.push_back({4'h0, op});
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({cs, rd, wr} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes got %b want 111", {cs, rd, wr}); end
    n_cmp++; if (addr !== 6'd0 || databus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus addr %h data %h want 0 0", addr, databus_out); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp valid %b result %h timeout %b want 0", rsp_valid, rsp_result, rsp_timeout); end
    n_cmp++; if (end_ack !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state ack %b state %0d want 0 0", end_ack, dbg_state); end
    @(negedge clk); arst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_add();
    int cyc;
    logic [7:0] e;
    run_op(32'h3F800000, 32'h40000000, 4'd0, 32'h40400000, cyc);
    n_cmp++; if (cyc !== LAT) begin n_fail++; $display("FAIL add_latency got %0d want %0d", cyc, LAT); end
    n_cmp++; if (rsp_result !== 32'h40400000 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL add_result got %h/%b want 40400000/0", rsp_result, rsp_timeout); end
    n_cmp++; if (wr_addr_q.size() != 9 || rd_addr_q.size() != 4) begin n_fail++; $display("FAIL add_counts writes %0d reads %0d want 9 4", wr_addr_q.size(), rd_addr_q.size()); end
    for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== e) begin n_fail++; $display("FAIL add_write%0d got %h:%h want %h:%h", i, wr_addr_q[i], wr_data_q[i], 6'(i), e); end
    end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      n_cmp++; if (rd_addr_q[i] !== 6'(9 + i)) begin n_fail++; $display("FAIL add_read%0d addr %h want %h", i, rd_addr_q[i], 6'(9 + i)); end
    end
    n_cmp++; if (ack_cyc != EXP_ACK) begin n_fail++; $display("FAIL add_end_ack cycles %0d want %0d", ack_cyc, EXP_ACK); end
    release_rsp();
    n_cmp++; if (rsp_valid !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL add_release valid %b state %0d want 0 0", rsp_valid, dbg_state); end
  endtask

  task automatic test_mul();
    int cyc;
    logic [7:0] e;
    run_op(32'h40000000, 32'h40400000, 4'd2, 32'h40C00000, cyc);
    n_cmp++; if (rsp_result !== 32'h40C00000) begin n_fail++; $display("FAIL mul_result got %h want 40c00000", rsp_result); end
    n_cmp++; if (cyc !== LAT) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", cyc, LAT); end
    for (int i = 0; i < 9 && i < wr_data_q.size(); i++) begin
      e = exp_q.pop_front();
      n_cmp++; if (wr_data_q[i] !== e) begin n_fail++; $display("FAIL mul_write%0d got %h want %h", i, wr_data_q[i], e); end
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int cyc;
    run_op(32'h3F800000, 32'h3F800000, 4'd0, 32'h40000000, cyc);
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h40000000 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d valid %b result %h ready %b want 1 40000000 0", i, rsp_valid, rsp_result, req_ready); end
    end
    req_valid = 1'b0;
    release_rsp();
    n_cmp++; if (rsp_valid !== 1'b0 || dbg_state !== 3'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release valid %b state %0d ready %b want 0 0 1", rsp_valid, dbg_state, req_ready); end
  endtask

  task automatic test_busy();
    int cyc;
    @(negedge clk);
    clear_model(32'h40400000);
    busy = 1'b1; req_valid = 1'b1; req_a = 32'h40C00000; req_b = 32'h40000000; req_op = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (req_ready !== 1'b0 || cs !== 1'b1) begin n_fail++; $display("FAIL busy_block%0d ready %b cs %b want 0 1", i, req_ready, cs); end
    end
    busy = 1'b0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL busy_drop ready %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (cs !== 1'b0 || dbg_state !== 3'd1) begin n_fail++; $display("FAIL busy_accept cs %b state %0d want 0 1", cs, dbg_state); end
    cyc = 1;
    while (!rsp_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (rsp_result !== 32'h40400000 || cyc !== LAT) begin n_fail++; $display("FAIL busy_result got %h after %0d want 40400000 after %0d", rsp_result, cyc, LAT); end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    int guard;
    int cyc;
    @(negedge clk);
    clear_model(32'h0);
    req_valid = 1'b1; req_a = 32'h11223344; req_b = 32'h55667788; req_op = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (wr_addr_q.size() < 5 && guard < 200) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (wr_addr_q.size() != 5 || wr_addr_q[4] !== 6'd4) begin n_fail++; $display("FAIL rstmid_reach writes %0d want 5 (byte 4)", wr_addr_q.size()); end
    arst = 1'b0; #1;
    n_cmp++; if ({cs, rd, wr} !== 3'b111 || rsp_valid !== 1'b0 || addr !== 6'd0) begin n_fail++; $display("FAIL rstmid_outputs cs/rd/wr %b valid %b addr %h want 111 0 0", {cs, rd, wr}, rsp_valid, addr); end
    @(negedge clk); @(negedge clk); arst = 1'b1;
    run_op(32'h40400000, 32'h3F800000, 4'd1, 32'h40000000, cyc);
    n_cmp++; if (rsp_result !== 32'h40000000 || cyc !== LAT || wr_addr_q.size() != 9) begin n_fail++; $display("FAIL rstmid_after result %h lat %0d writes %0d want 40000000 %0d 9", rsp_result, cyc, wr_addr_q.size(), LAT); end
    release_rsp();
  endtask

`ifdef FPU_MASTER_IRQ_WAIT_EN
  task automatic test_timeout();
    int cyc;
    irq_on = 1'b0;
    run_op(32'h3F800000, 32'h40000000, 4'd0, 32'h40400000, cyc);
    n_cmp++; if (cyc !== 9 * (2 + S) + TMO + 1) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", cyc, 9 * (2 + S) + TMO + 1); end
    n_cmp++; if (rsp_timeout !== 1'b1 || rsp_result !== 32'd0) begin n_fail++; $display("FAIL tmo_rsp timeout %b result %h want 1 0", rsp_timeout, rsp_result); end
    n_cmp++; if (rd_addr_q.size() != 0 || ack_cyc != 0) begin n_fail++; $display("FAIL tmo_bus reads %0d acks %0d want 0 0", rd_addr_q.size(), ack_cyc); end
    release_rsp();
    irq_on = 1'b1;
  endtask

  task automatic test_irq();
    int cyc;
    run_op(32'h40000000, 32'h40000000, 4'd2, 32'h40800000, cyc);
    n_cmp++; if (cyc !== LAT || ack_cyc != 1) begin n_fail++; $display("FAIL irq_ack latency %0d ack cycles %0d want %0d 1", cyc, ack_cyc, LAT); end
    n_cmp++; if (rsp_timeout !== 1'b0 || rsp_result !== 32'h40800000 || rd_addr_q.size() != 4) begin n_fail++; $display("FAIL irq_rsp timeout %b result %h reads %0d want 0 40800000 4", rsp_timeout, rsp_result, rd_addr_q.size()); end
    release_rsp();
  endtask
`endif

  task automatic test_bus_rules();
    n_cmp++; if (cs_err != 0) begin n_fail++; $display("FAIL cs_rule strobes without cs %0d want 0", cs_err); end
    n_cmp++; if (width_err != 0) begin n_fail++; $display("FAIL strobe_width bad strobes %0d want 0", width_err); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_busy();
    test_reset_mid();
`ifdef FPU_MASTER_IRQ_WAIT_EN
    test_timeout();
    test_irq();
`endif
    test_bus_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
